// File: rtl/step_clock_gen.sv
// Debounced single-step / auto-step clock generator for the DE0 bring-up top.
// Define STEP_COUNTER_EN to build the 16-bit step counter; otherwise step_count reads 0.
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned PULSE_WIDTH     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        button_n,
  input  logic        run_sw,
  input  logic        count_clr,
  output logic        step_pulse,
  output logic        step_clock,
  output logic [15:0] step_count,
  output logic        btn_level
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DIV_W = $clog2(RUN_DIV);
  localparam int unsigned PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  logic [1:0]       btn_sync;
  logic [1:0]       run_sync;
  logic             btn;
  logic             run;
  db_state_e        state;
  logic [DB_W-1:0]  db_cnt;
  logic             press_veto;
  logic [DIV_W-1:0] div_cnt;
  logic [PW_W-1:0]  width_cnt;
  logic             press_event;
  logic             auto_step;
  logic             step_next;

  // Button synchroniser resets to "released" so a reset never fakes a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync <= 2'b11;
      run_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so each flop samples pre-edge values.
      btn_sync <= {btn_sync[0], button_n};
      run_sync <= {run_sync[0], run_sw};
    end
  end

  assign btn = ~btn_sync[1];
  assign run = run_sync[1];

  // press_veto remembers that run was high at any point during a press debounce,
  // so flipping the switch mid-press can never leak a manual step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      db_cnt     <= '0;
      press_veto <= 1'b0;
      btn_level  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn) begin
            state      <= PRESS_WAIT;
            db_cnt     <= '0;
            press_veto <= run;
          end
        end
        PRESS_WAIT: begin
          if (!btn) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state     <= HELD;
            btn_level <= 1'b1;
          end else begin
            db_cnt     <= db_cnt + 1'b1;
            press_veto <= press_veto | run;
          end
        end
        HELD: begin
          if (!btn) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press_event = (state == PRESS_WAIT) && btn && (db_cnt == DB_LAST) && !run && !press_veto;
  assign auto_step   = run && (div_cnt == DIV_LAST);
  assign step_next   = press_event | auto_step;

  // Divider parks at 0 in manual mode so the first auto-step is a full period away.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A new step while stretched reloads the width counter, keeping step_clock high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_pulse <= 1'b0;
      step_clock <= 1'b0;
      width_cnt  <= '0;
    end else begin
      step_pulse <= step_next;
      if (step_next) begin
        step_clock <= 1'b1;
        width_cnt  <= PW_LAST;
      end else if (step_clock) begin
        if (width_cnt == '0) begin
          step_clock <= 1'b0;
        end else begin
          width_cnt <= width_cnt - 1'b1;
        end
      end
    end
  end

`ifdef STEP_COUNTER_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (count_clr) begin
      count_q <= '0;
    end else if (step_pulse) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign step_count = count_q;
`else
  logic unused_count_clr;

  assign unused_count_clr = count_clr;
  assign step_count       = 16'h0000;
`endif

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed bench for step_clock_gen: expected pulse cycles go into a scoreboard
// queue as stimulus is driven and are popped by a monitor when step_pulse fires.
module tb_step_clock_gen;

  logic        clock;
  logic        reset_n;
  logic        button_n;
  logic        run_sw;
  logic        count_clr;
  logic        step_pulse;
  logic        step_clock;
  logic [15:0] step_count;
  logic        btn_level;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_q[$];
  logic [15:0] model_cnt;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (8),
    .PULSE_WIDTH    (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .button_n  (button_n),
    .run_sw    (run_sw),
    .count_clr (count_clr),
    .step_pulse(step_pulse),
    .step_clock(step_clock),
    .step_count(step_count),
    .btn_level (btn_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cyc == n during the cycle that follows rising edge n
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_count(input logic [15:0] m);
`ifdef STEP_COUNTER_EN
    return m;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset_n && step_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", cyc, 32'hFFFF_FFFF);
      end else begin
        check("pulse_cycle", cyc, exp_q.pop_front());
        check("clock_with_pulse", 32'(step_clock), 32'd1);
      end
    end
  end

  initial begin
    int c;
    int q;
    reset_n   = 1'b0;
    button_n  = 1'b1;
    run_sw    = 1'b0;
    count_clr = 1'b0;
    model_cnt = '0;

    repeat (3) @(negedge clock);
    check("rst_step_pulse", 32'(step_pulse), 32'd0);
    check("rst_step_clock", 32'(step_clock), 32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    check("rst_btn_level", 32'(btn_level), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Clean press: pulse 2 sync + 4 debounce edges after first low sample.
    c = cyc;
    button_n = 1'b0;
    exp_q.push_back(c + 7);
    model_cnt++;
    wait_cyc(c + 6);
    check("t1_level_before", 32'(btn_level), 32'd0);
    wait_cyc(c + 7);
    check("t1_level_after", 32'(btn_level), 32'd1);
    check("t1_clk_hi0", 32'(step_clock), 32'd1);
    wait_cyc(c + 8);
    check("t1_clk_hi1", 32'(step_clock), 32'd1);
    wait_cyc(c + 9);
    check("t1_clk_lo", 32'(step_clock), 32'd0);
    wait_cyc(c + 20);
    button_n = 1'b1;
    wait_cyc(c + 32);
    check("t1_count", 32'(step_count), 32'(exp_count(model_cnt)));
    check("t1_level_rel", 32'(btn_level), 32'd0);
    check("t1_queue", exp_q.size(), 32'd0);

    // Press bounce: low 2, high 1, low 2, high
    c = cyc;
    button_n = 1'b0;
    wait_cyc(c + 2);
    button_n = 1'b1;
    wait_cyc(c + 3);
    button_n = 1'b0;
    wait_cyc(c + 5);
    button_n = 1'b1;
    wait_cyc(c + 7);
    check("t2_level_mid", 32'(btn_level), 32'd0);
    wait_cyc(c + 12);
    check("t2_level_end", 32'(btn_level), 32'd0);
    check("t2_count", 32'(step_count), 32'(exp_count(model_cnt)));
    check("t2_queue", exp_q.size(), 32'd0);

    // Accepted press followed by release bounce
    c = cyc;
    button_n = 1'b0;
    exp_q.push_back(c + 7);
    model_cnt++;
    wait_cyc(c + 12);
    check("t3_held", 32'(btn_level), 32'd1);
    for (int i = 0; i < 3; i++) begin
      button_n = 1'b1;
      @(negedge clock);
      button_n = 1'b0;
      @(negedge clock);
    end
    c = cyc;
    button_n = 1'b1;
    wait_cyc(c + 6);
    check("t3_level_bounce", 32'(btn_level), 32'd1);
    wait_cyc(c + 7);
    check("t3_level_idle", 32'(btn_level), 32'd0);
    wait_cyc(c + 10);
    check("t3_count", 32'(step_count), 32'(exp_count(model_cnt)));
    check("t3_queue", exp_q.size(), 32'd0);

    // Run mode with button activity: only divider steps
    count_clr = 1'b1;
    @(negedge clock);
    count_clr = 1'b0;
    model_cnt = '0;
    check("t4_cleared", 32'(step_count), 32'd0);
    c = cyc;
    run_sw = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(c + 10 + 8 * k);
    model_cnt += 16'd4;
    wait_cyc(c + 3);
    button_n = 1'b0;
    wait_cyc(c + 12);
    check("t4_level_tracks", 32'(btn_level), 32'd1);
    wait_cyc(c + 13);
    button_n = 1'b1;
    wait_cyc(c + 23);
    button_n = 1'b0;
    wait_cyc(c + 33);
    button_n = 1'b1;
    wait_cyc(c + 38);
    run_sw = 1'b0;
    wait_cyc(c + 50);
    check("t4_count", 32'(step_count), 32'(exp_count(model_cnt)));
    check("t4_level_end", 32'(btn_level), 32'd0);
    check("t4_queue", exp_q.size(), 32'd0);

    // Counter wrap and clear priority
`ifdef STEP_COUNTER_EN
    force dut.count_q = 16'hFFFF;
    @(negedge clock);
    release dut.count_q;
    model_cnt = 16'hFFFF;
    @(negedge clock);
    check("t5_preset", 32'(step_count), 32'h0000_FFFF);
`endif
    c = cyc;
    button_n = 1'b0;
    exp_q.push_back(c + 7);
    model_cnt++;
    wait_cyc(c + 9);
    check("t5_wrap", 32'(step_count), 32'(exp_count(model_cnt)));
    button_n = 1'b1;
    wait_cyc(c + 20);
    c = cyc;
    button_n = 1'b0;
    exp_q.push_back(c + 7);
    model_cnt++;
    wait_cyc(c + 9);
    check("t5_incr", 32'(step_count), 32'(exp_count(model_cnt)));
    button_n = 1'b1;
    wait_cyc(c + 20);
    c = cyc;
    button_n = 1'b0;
    exp_q.push_back(c + 7);
    wait_cyc(c + 7);
    count_clr = 1'b1;
    wait_cyc(c + 8);
    count_clr = 1'b0;
    model_cnt = '0;
    wait_cyc(c + 9);
    check("t5_clr_priority", 32'(step_count), 32'(exp_count(model_cnt)));
    button_n = 1'b1;
    wait_cyc(c + 20);

    // Async reset while stretched and mid press debounce
    c = cyc;
    run_sw = 1'b1;
    exp_q.push_back(c + 10);
    wait_cyc(c + 6);
    button_n = 1'b0;
    wait_cyc(c + 10);
    #1;
    reset_n = 1'b0;
    run_sw  = 1'b0;
    #1;
    check("t6_rst_clock", 32'(step_clock), 32'd0);
    check("t6_rst_pulse", 32'(step_pulse), 32'd0);
    check("t6_rst_level", 32'(btn_level), 32'd0);
    check("t6_rst_count", 32'(step_count), 32'd0);
    model_cnt = '0;
    @(negedge clock);
    q = cyc;
    reset_n = 1'b1;
    exp_q.push_back(q + 7);
    model_cnt++;
    wait_cyc(q + 6);
    check("t6_no_early_pulse", 32'(step_pulse), 32'd0);
    check("t6_level_before", 32'(btn_level), 32'd0);
    wait_cyc(q + 7);
    check("t6_level_after", 32'(btn_level), 32'd1);
    wait_cyc(q + 10);
    button_n = 1'b1;
    wait_cyc(q + 25);
    check("t6_count", 32'(step_count), 32'(exp_count(model_cnt)));
    check("final_queue", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Front end for the DE0 bring-up top. Turns a raw, bouncy, active-low DE0 push-button into a clean single-step pulse and a stretched step clock.
- The step clock drives ProgramCounter and the CPU datapath in place of a raw button.
- Also provides a free-running auto-step mode selected by a slide switch.
- Provides a 16-bit step count for the quad 7-segment decoder / GPIO board displays.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles required before a press or release is accepted (10 ms at 50 MHz); must be >= 2.
- RUN_DIV, 25000000, clock cycles between auto-steps in run mode; must be > PULSE_WIDTH + 1.
- PULSE_WIDTH, 4, cycles step_clock stays high per step; must be >= 1.

Ports:
- clock  input  1  system clock (CLOCK_50).
- reset_n  input  1  asynchronous, active-low reset.
- button_n  input  1  raw DE0 push-button, active-low, asynchronous to clock.
- run_sw  input  1  raw slide switch; 1 = auto-step mode, 0 = manual step.
- count_clr  input  1  synchronous clear of step_count, active-high.
- step_pulse  output  1  one-cycle strobe per accepted step.
- step_clock  output  1  step clock for downstream sequential logic; high for PULSE_WIDTH cycles per step.
- step_count  output  16  number of steps since reset or clear.
- btn_level  output  1  debounced button level (1 = pressed), for LED display.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All flops clear: step_pulse=0, step_clock=0, step_count=0, btn_level=0, FSM=IDLE, all counters 0.
  - Synchroniser flops for button_n reset to 1 (released); run_sw synchroniser flops reset to 0.
- Synchronisers:
  - button_n and run_sw each pass through a 2-flop synchroniser.
  - btn = ~sync(button_n); run = sync(run_sw).
- Debounce FSM (cnt is a counter wide enough for DEBOUNCE_CYCLES-1):
  - IDLE: btn=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: btn=0 -> IDLE; else if cnt==DEBOUNCE_CYCLES-1 -> HELD and issue press event; else cnt+1.
  - HELD: btn=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: btn=1 -> HELD with no new event; else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
- btn_level: 1 in HELD and RELEASE_WAIT, 0 otherwise.
- Manual-mode latency:
  - If button_n is first sampled low at edge j and stays low, step_pulse is high for exactly the cycle following edge j+2+DEBOUNCE_CYCLES.
  - Exactly one pulse per accepted press; holding the button gives no auto-repeat.
- Run mode (run=1):
  - Divider counts 0..RUN_DIV-1 and wraps; step_pulse asserts for the one cycle after each wrap.
  - Divider is held at 0 while run=0, so the first auto-step arrives RUN_DIV cycles after run rises.
  - Press events from the FSM are discarded while run=1; the FSM keeps tracking so btn_level stays valid.
  - Changing run mid-press does not produce a pulse.
- step_clock:
  - Rises in the same cycle as step_pulse and stays high for PULSE_WIDTH cycles.
  - If step_pulse arrives while step_clock is high, the width counter reloads; there is no glitch-low.
  - step_clock is a registered flop output only.
- step_count:
  - +1 on each step_pulse; wraps 0xFFFF -> 0x0000.
  - count_clr=1 forces 0 next edge and takes priority over a simultaneous increment.
- Reset mid-debounce or mid-stretch aborts immediately. After reset, a button still held must first pass a full press debounce.

Optional Feature:
- Macro: STEP_COUNTER_EN.
- Defined: step_count behaves as above.
- Undefined: the counter logic is not synthesised, step_count is tied to 16'h0000, and count_clr is ignored. All other behaviour is identical.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, RUN_DIV=8, PULSE_WIDTH=2):
1. Reset, then button_n low from edge 10 held 20 cycles -> single step_pulse in the cycle after edge 16; step_clock high for 2 cycles; step_count=1; btn_level=1 from edge 16.
2. Bounce: button_n low 2 cycles, high 1, low 2, high 5 -> no step_pulse; step_count stays 0; btn_level stays 0.
3. Release bounce: after an accepted press, button_n toggles high 1 cycle / low 1 cycle three times then stays high -> no second pulse; btn_level returns to 0 four cycles after settling (FSM reaches IDLE).
4. run_sw=1 for 40 cycles while button_n is pressed repeatedly -> pulses every 8 cycles only (4 pulses, first 8 cycles after run syncs); step_count=4; no pulses from the button.
5. step_count=0xFFFF plus one step -> 0x0000; count_clr coincident with a step_pulse -> step_count=0x0000.
6. reset_n asserted asynchronously while step_clock is high and the FSM is in PRESS_WAIT -> all outputs 0 immediately; no pulse after release until a full new debounce completes.
